// File: rtl/predictor_pkg.sv
// Shared types and helpers for the bimodal branch predictor: 2-bit counter
// state encodings, saturating counter arithmetic and PC-to-index extraction.
package predictor_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr2_e;

   // Saturating step for a counter of up to 4 bits; upper bits beyond ctr_w are zero.
   function automatic logic [3:0] sat_next(input logic [3:0] ctr, input logic up, input int ctr_w);
      logic [3:0] max_val;
      max_val = 4'((1 << ctr_w) - 1);
      if (up) return (ctr == max_val) ? ctr : ctr + 4'd1;
      else    return (ctr == 4'd0)    ? ctr : ctr - 4'd1;
   endfunction

   function automatic logic [31:0] calc_index(input logic [63:0] pc, input int pc_lsb, input int idx_w);
      logic [63:0] mask;
      mask = (64'd1 << idx_w) - 64'd1;
      return 32'((pc >> pc_lsb) & mask);
   endfunction

endpackage

// File: rtl/bimodal_predictor_sat_counter.sv
// One saturating direction counter of the prediction table.
module sat_counter
   import predictor_pkg::*;
#(
   parameter int CTR_W    = 2,
   parameter int CTR_INIT = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_en,
   input  logic             dec_en,
   output logic [CTR_W-1:0] ctr
);

   // NOTE: table entries are individually reset flops, so a reset wipes all training at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctr <= CTR_W'(CTR_INIT);
      end else if (inc_en || dec_en) begin
         // NOTE: non-blocking assignment keeps every counter update on the same edge semantics.
         ctr <= CTR_W'(sat_next(4'(ctr), inc_en, CTR_W));
      end
   end

endmodule

// File: rtl/bimodal_predictor.sv
// Bimodal branch direction predictor with registered prediction output.
// Optional global-history XOR indexing is enabled by BIMODAL_PREDICTOR_GSHARE_EN.
module bimodal_predictor
   import predictor_pkg::*;
#(
   parameter int PC_W     = 32,
   parameter int ENTRIES  = 64,
   parameter int CTR_W    = 2,
   parameter int PC_LSB   = 2,
   parameter int CTR_INIT = 0,
   parameter int HIST_W   = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            request,
   input  logic [PC_W-1:0] req_pc,
   input  logic            result,
   input  logic [PC_W-1:0] res_pc,
   input  logic            taken,
   output logic            prediction,
   output logic            pred_valid
);

   localparam int IDX_W = $clog2(ENTRIES);

   logic [IDX_W-1:0] req_base;
   logic [IDX_W-1:0] res_base;
   logic [IDX_W-1:0] req_idx;
   logic [IDX_W-1:0] upd_idx;
   logic [CTR_W-1:0] ctr_q [ENTRIES];

   assign req_base = IDX_W'(calc_index(64'(req_pc), PC_LSB, IDX_W));
   assign res_base = IDX_W'(calc_index(64'(res_pc), PC_LSB, IDX_W));

`ifdef BIMODAL_PREDICTOR_GSHARE_EN
   logic [HIST_W-1:0] hist;

   // Both lookups see the history from before this cycle's shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      hist <= '0;
      else if (result) hist <= {hist[HIST_W-2:0], taken};
   end

   assign req_idx = req_base ^ IDX_W'(hist);
   assign upd_idx = res_base ^ IDX_W'(hist);
`else
   localparam int HIST_W_UNUSED = HIST_W;

   assign req_idx = req_base;
   assign upd_idx = res_base;
`endif

   for (genvar i = 0; i < ENTRIES; i++) begin : g_table
      logic hit;
      assign hit = result && (upd_idx == IDX_W'(i));

      sat_counter #(
         .CTR_W    (CTR_W),
         .CTR_INIT (CTR_INIT)
      ) u_ctr (
         .clk    (clk),
         .rst_n  (rst_n),
         .inc_en (hit && taken),
         .dec_en (hit && !taken),
         .ctr    (ctr_q[i])
      );
   end

   // Reads the pre-edge counter value, so a same-cycle update to the same entry is not seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prediction <= 1'b0;
         pred_valid <= 1'b0;
      end else begin
         pred_valid <= request;
         if (request) prediction <= ctr_q[req_idx][CTR_W-1];
      end
   end

endmodule

// File: tb/tb_bimodal_predictor.sv
// Scoreboard bench for bimodal_predictor: directed vectors push expected
// predictions, a negedge monitor pops and compares whenever pred_valid is high.
module tb_bimodal_predictor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        request;
   logic [31:0] req_pc;
   logic        result;
   logic [31:0] res_pc;
   logic        taken;
   logic        prediction;
   logic        pred_valid;

   int vectors     = 0;
   int miscompares = 0;
   bit exp_q [$];

   bimodal_predictor dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .request    (request),
      .req_pc     (req_pc),
      .result     (result),
      .res_pc     (res_pc),
      .taken      (taken),
      .prediction (prediction),
      .pred_valid (pred_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, take the edge, then return the bus to idle.
   task automatic cycle(input bit rq, input logic [31:0] rpc, input bit rs,
                        input logic [31:0] spc, input bit tk, input bit exp);
      request = rq; req_pc = rpc; result = rs; res_pc = spc; taken = tk;
      if (rq) exp_q.push_back(exp);
      @(posedge clk);
      #1;
      request = 1'b0; result = 1'b0; taken = 1'b0;
   endtask

   task automatic predict(input logic [31:0] pc, input bit exp);
      cycle(1'b1, pc, 1'b0, 32'h0, 1'b0, exp);
   endtask

   task automatic train(input logic [31:0] pc, input bit tk, input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b1, pc, tk, 1'b0);
   endtask

   always @(negedge clk) begin
      if (rst_n && pred_valid) begin
         if (exp_q.size() == 0) check("unexpected_pred_valid", 32'd1, 32'd0);
         else                   check("prediction", 32'(prediction), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; request = 1'b0; req_pc = '0; result = 1'b0; res_pc = '0; taken = 1'b0;
      #12;
      check("reset_pred_valid", 32'(pred_valid), 32'd0);
      check("reset_prediction", 32'(prediction), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

`ifdef BIMODAL_PREDICTOR_GSHARE_EN
      // History 1,0,1 at pc 0 -> hist=0x05; counters 0 and 2 become 1.
      train(32'h0, 1'b1, 1);
      train(32'h0, 1'b0, 1);
      train(32'h0, 1'b1, 1);
      train(32'h40, 1'b1, 1);   // 16^0x05 = 21 -> ctr[21]=1, hist=0x0B
      train(32'h78, 1'b1, 1);   // 30^0x0B = 21 -> ctr[21]=2, hist=0x17
      predict(32'h08, 1'b1);    // 2^0x17 = 21
      predict(32'h1C, 1'b0);    // 7^0x17 = 16, never trained
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
`else
      // Cold lookup, then pred_valid must drop on an idle cycle.
      predict(32'h40, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      #4 check("idle_pred_valid", 32'(pred_valid), 32'd0);
      check("idle_prediction_hold", 32'(prediction), 32'd0);

      train(32'h40, 1'b1, 4);   // saturates at ST
      predict(32'h40, 1'b1);
      train(32'h40, 1'b1, 1);   // stays at ST
      predict(32'h40, 1'b1);
      train(32'h40, 1'b0, 1);   // WT
      predict(32'h40, 1'b1);
      train(32'h40, 1'b0, 1);   // WNT
      predict(32'h40, 1'b0);
      train(32'h40, 1'b0, 2);   // floor at SNT
      predict(32'h40, 1'b0);
      train(32'h40, 1'b1, 1);   // WNT
      predict(32'h40, 1'b0);

      // Same-cycle read and update of entry 16: old WNT value is predicted.
      cycle(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0);
      predict(32'h40, 1'b1);    // now WT

      train(32'h40, 1'b1, 1);   // ST
      predict(32'h140, 1'b1);   // aliases entry 16
      predict(32'h44, 1'b0);    // entry 17 untouched

      // Asynchronous reset while a taken prediction is being presented.
      predict(32'h40, 1'b1);
      #6;
      check("pre_reset_pred_valid", 32'(pred_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_reset_pred_valid", 32'(pred_valid), 32'd0);
      check("async_reset_prediction", 32'(prediction), 32'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      predict(32'h40, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
`endif

      #4;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
